// File: rtl/trace_scheduler_pkg.sv
// Shared types and constants for the trace scheduler: FSM states, default
// geometry, index widths and the saturating wrap-count helper.
package trace_pkg;

   localparam int TRACE_DEPTH    = 32;
   localparam int TRACE_CHANNELS = 4;

   localparam logic [7:0] WRAPS_MAX = 8'd255;

   typedef logic [$clog2(TRACE_DEPTH)-1:0]    step_t;
   typedef logic [$clog2(TRACE_CHANNELS)-1:0] chan_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [7:0] wraps_sat_inc(input logic [7:0] v);
      return (v == WRAPS_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/trace_scheduler_if.sv
// Configuration, control and trace-output bundle between the bench driver
// (master) and the scheduler (slave).
interface trace_scheduler_if
   import trace_pkg::*;
#(
   parameter int DEPTH    = TRACE_DEPTH,
   parameter int CHANNELS = TRACE_CHANNELS
);
   logic                        cfg_we;
   logic [$clog2(CHANNELS)-1:0] cfg_chan;
   logic [$clog2(DEPTH)-1:0]    cfg_step;
   logic                        cfg_val;
   logic                        cfg_ready;
   logic                        start;
   logic                        stop;
   logic                        loop;
   logic                        step_en;
   logic [CHANNELS-1:0]         trace_out;
   logic [$clog2(DEPTH)-1:0]    t;
   logic                        busy;
   logic                        done;
   logic [7:0]                  wraps;

   modport master (
      output cfg_we, cfg_chan, cfg_step, cfg_val, start, stop, loop, step_en,
      input  cfg_ready, trace_out, t, busy, done, wraps
   );

   modport slave (
      input  cfg_we, cfg_chan, cfg_step, cfg_val, start, stop, loop, step_en,
      output cfg_ready, trace_out, t, busy, done, wraps
   );
endinterface

// File: rtl/trace_mem.sv
// CHANNELS x DEPTH trace bit store: synchronous clear, one bit-write port and
// a combinational column read (all channels at one step).
module trace_mem
#(
   parameter int DEPTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_we,
   input  logic [$clog2(CHANNELS)-1:0] i_chan,
   input  logic [$clog2(DEPTH)-1:0]    i_step,
   input  logic                        i_val,
   input  logic [$clog2(DEPTH)-1:0]    i_rd_step,
   output logic [CHANNELS-1:0]         o_col
);
   logic [DEPTH-1:0] r_mem [CHANNELS];
   logic             w_chan_ok;

   // Channel indices beyond the populated rows are dropped.
   assign w_chan_ok = (int'(i_chan) < CHANNELS);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_mem[c] <= '0;
         end
      end else if (i_we && w_chan_ok) begin
         r_mem[i_chan][i_step] <= i_val;
      end
   end

   always_comb begin
      o_col = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         o_col[c] = r_mem[c][i_rd_step];
      end
   end

endmodule

// File: rtl/trace_scheduler.sv
// Run-time programmable trace player: IDLE/RUN/DONE sequencer with pause,
// stop, looping and a saturating wrap counter over a trace_mem store.
module trace_scheduler
   import trace_pkg::*;
#(
   parameter int DEPTH    = TRACE_DEPTH,
   parameter int CHANNELS = TRACE_CHANNELS
) (
   input  logic              clock,
   input  logic              reset,
   trace_scheduler_if.slave  bus
);
   localparam int             SW   = $clog2(DEPTH);
   localparam logic [SW-1:0]  LAST = SW'(DEPTH - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SW-1:0]         r_t;
   logic [SW-1:0]         w_t_nxt;
   logic                  r_loop;
   logic                  w_loop_nxt;
   logic [7:0]            r_wraps;
   logic [7:0]            w_wraps_nxt;
   logic                  w_cfg_ready;
   logic                  w_we;
   logic [CHANNELS-1:0]   w_col;

   // Writes are only honoured while the player is not consuming the store.
   assign w_cfg_ready = (r_state != ST_RUN);
   assign w_we        = bus.cfg_we & w_cfg_ready;

   trace_mem #(
      .DEPTH    (DEPTH),
      .CHANNELS (CHANNELS)
   ) u_mem (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_we      (w_we),
      .i_chan    (bus.cfg_chan),
      .i_step    (bus.cfg_step),
      .i_val     (bus.cfg_val),
      .i_rd_step (r_t),
      .o_col     (w_col)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_t     <= '0;
         r_loop  <= 1'b0;
         r_wraps <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_loop  <= w_loop_nxt;
         r_wraps <= w_wraps_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_loop_nxt  = r_loop;
      w_wraps_nxt = r_wraps;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_RUN;
               w_t_nxt     = '0;
               w_loop_nxt  = bus.loop;
               w_wraps_nxt = 8'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
               w_t_nxt     = '0;
            end else if (!bus.step_en) begin
               w_t_nxt = r_t;
            end else if (r_t != LAST) begin
               w_t_nxt = r_t + SW'(1);
            end else if (r_loop) begin
               w_t_nxt     = '0;
               w_wraps_nxt = wraps_sat_inc(r_wraps);
            end else begin
               // Finishing keeps t on the last step for the DONE observer.
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
               w_t_nxt     = '0;
            end else if (bus.start) begin
               w_state_nxt = ST_RUN;
               w_t_nxt     = '0;
               w_loop_nxt  = bus.loop;
               w_wraps_nxt = 8'd0;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_t_nxt     = '0;
         end
      endcase
   end

   assign bus.cfg_ready = w_cfg_ready;
   assign bus.trace_out = (r_state == ST_RUN) ? w_col : '0;
   assign bus.t         = r_t;
   assign bus.busy      = (r_state == ST_RUN);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.wraps     = r_wraps;

endmodule

// File: doc/trace_scheduler.md
# trace_scheduler

Programmable stimulus controller for the SVA regression benches: it stores up to four one-bit channel traces of DEPTH steps and plays them out one step per enabled clock. Playback supports start/stop, pause and looping. It replaces fixed string-parameter trace generators so one bench instance can sequence many A/B/C/D scenarios at run time. It sits between the bench driver (configuration and control) and the properties under test (trace outputs).

## Interface
- DEPTH, 32, steps per trace; power of two, ≥ 2
- CHANNELS, 4, number of trace channels
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write one trace bit
- cfg_chan  in  $clog2(CHANNELS)  channel to write
- cfg_step  in  $clog2(DEPTH)  step to write
- cfg_val  in  1  bit value to write
- cfg_ready  out  1  high in IDLE or DONE; writes accepted only then
- start  in  1  begin playback at step 0
- stop  in  1  abort playback, return to IDLE
- loop  in  1  sampled on an accepted start; wrap instead of finishing
- step_en  in  1  advance enable; low pauses in place
- trace_out  out  CHANNELS  bit c = mem[c][t] while busy, else 0
- t  out  $clog2(DEPTH)  current step index
- busy  out  1  state == RUN
- done  out  1  state == DONE
- wraps  out  8  completed loop wraps since last start, saturating at 255

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, t=0, wraps=0, loop_r=0, all trace bits cleared to 0. Every output is 0 during and after reset, except cfg_ready=1.
- IDLE: start → RUN, t=0, loop_r=loop, wraps=0. stop has no effect.
- RUN:
  - stop → IDLE, t=0. stop has priority over start and step_en.
  - start has no effect.
  - step_en=0: t holds.
  - step_en=1 and t<DEPTH-1: t+1.
  - step_en=1 and t==DEPTH-1 with loop_r=1: t=0, wraps+1 (saturating), stay RUN.
  - step_en=1 and t==DEPTH-1 with loop_r=0: → DONE, t holds DEPTH-1.
- DONE:
  - start → RUN, same as from IDLE.
  - stop → IDLE, t=0.
  - Otherwise hold. wraps holds its value.
- Config writes: a cfg_we with cfg_ready=1 updates mem[cfg_chan][cfg_step] at the edge. cfg_we while busy is silently dropped. A cfg_chan ≥ CHANNELS write is dropped.
- trace_out is combinational from registered t, registered state and the memory. No combinational path from any input to any output.

## Timing
- start sampled at edge k → busy=1, t=0, trace_out=step 0 during cycle k+1.
- With step_en held high and loop=0, step i is presented in cycle k+1+i. done=1 and busy=0 from cycle k+1+DEPTH.
- With loop=1, step 0 reappears in cycle k+1+DEPTH, and wraps=1 in that cycle.
- A write and a start in the same cycle in IDLE: the written bit is visible from cycle k+1.
- stop at edge k: trace_out=0 and t=0 from cycle k+1.
- reset has priority over all inputs. Reset mid-RUN aborts playback and clears the memory in the same edge.

## Structure
- Package trace_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default DEPTH/CHANNELS localparams
  - the step-index and channel-index width typedefs
  - the WRAPS_MAX constant
- Sub-module trace_mem: CHANNELS×DEPTH bit array with synchronous reset-clear, a single write port (we, chan, step, val) and a column read port (step → CHANNELS bits). trace_scheduler instantiates one trace_mem and holds the FSM, t counter, loop_r and wraps.

## Test plan
- Load ch0 step1=1, ch1 steps5..7=1, ch2 steps2..12=1, ch3 steps6,13=1; start with step_en=1 and loop=0 → trace_out equals the loaded pattern at cycles k+1..k+32; done=1 at k+33; t=31.
- Pause: start, drop step_en for 3 cycles at t=4 → t and trace_out hold step 4 for 4 cycles total, then resume at 5; done is delayed by exactly 3 cycles.
- Loop: loop=1, run 3×DEPTH+2 cycles → t wraps to 0 three times; wraps=3; busy never drops. Run 256 wraps → wraps saturates at 255.
- Stop/start priority: stop and start together in RUN at t=10 → IDLE, t=0, trace_out=0. A start while in RUN alone → t unaffected.
- Config gating: cfg_we ch0 step3=1 while busy, then run again after done → step 3 of ch0 still reads 0. The same write in DONE → step 3 reads 1 on the next run.
- Reset mid-RUN at t=7 → next cycle IDLE, t=0, all outputs 0, cfg_ready=1. A subsequent run with no writes → trace_out all 0 for all 32 steps.
